// File: rtl/lotto_session_arbiter.sv
// Round-robin session arbiter sharing one Lotto game among NUM_PLAYERS requesters.
// Optional per-player win counters are enabled by defining LOTTO_ARB_SCOREBOARD_EN.
module lotto_session_arbiter #(
  parameter int unsigned NUM_PLAYERS    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PLAYERS-1:0]           req,
  input  logic [2*NUM_PLAYERS-1:0]         ply_animal_in,
  input  logic [NUM_PLAYERS-1:0]           ply_animal_button,
  input  logic [32*NUM_PLAYERS-1:0]        ply_guess_in,
  input  logic [NUM_PLAYERS-1:0]           ply_guess_button,
  input  logic [15*NUM_PLAYERS-1:0]        ply_quiz_answers,
  input  logic [NUM_PLAYERS-1:0]           ply_quiz_submit,
  input  logic [2:0]                       game_stage,
  output logic                             game_rst_n,
  output logic [1:0]                       game_animal_in,
  output logic                             game_animal_button,
  output logic [31:0]                      game_guess_in,
  output logic                             game_guess_button,
  output logic [4:0]                       game_quiz_answer_1,
  output logic [4:0]                       game_quiz_answer_2,
  output logic [4:0]                       game_quiz_answer_3,
  output logic                             game_quiz_submit_button,
  output logic [NUM_PLAYERS-1:0]           grant,
  output logic                             busy,
  output logic                             result_valid,
  output logic                             result_win,
  output logic                             result_timeout,
  output logic [$clog2(NUM_PLAYERS)-1:0]   result_player
`ifdef LOTTO_ARB_SCOREBOARD_EN
  ,
  output logic [8*NUM_PLAYERS-1:0]         win_count
`endif
);

  localparam int unsigned PW = $clog2(NUM_PLAYERS);
  localparam logic [PW:0] NumP = (PW+1)'(NUM_PLAYERS);
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StGameRst, StPlay, StDone} state_e;

  state_e                 state_q, state_d;
  logic [NUM_PLAYERS-1:0] grant_q, grant_d;
  logic [PW-1:0]          gidx_q, gidx_d;
  logic [PW-1:0]          rr_ptr_q, rr_ptr_d;
  logic                   rst_cnt_q, rst_cnt_d;
  logic [15:0]            sess_cnt_q, sess_cnt_d;
  logic                   win_q, win_d;
  logic                   tmo_q, tmo_d;

  // Round-robin pick: rotate requests so rr_ptr lands at bit 0, take the lowest set bit.
  logic [2*NUM_PLAYERS-1:0] req_rot;
  logic                     sel_found;
  logic [PW-1:0]            sel_off;
  logic [PW:0]              sel_sum;
  logic [PW:0]              rr_inc;
  logic [PW-1:0]            sel_idx;
  logic [PW-1:0]            rr_next;

  assign req_rot = {req, req} >> rr_ptr_q;

  always_comb begin
    sel_found = 1'b0;
    sel_off   = '0;
    for (int j = NUM_PLAYERS - 1; j >= 0; j--) begin
      if (req_rot[j]) begin
        sel_found = 1'b1;
        sel_off   = PW'(j);
      end
    end
  end

  assign sel_sum = {1'b0, rr_ptr_q} + {1'b0, sel_off};
  assign sel_idx = (sel_sum >= NumP) ? PW'(sel_sum - NumP) : sel_sum[PW-1:0];
  assign rr_inc  = {1'b0, gidx_q} + {{PW{1'b0}}, 1'b1};
  assign rr_next = (rr_inc == NumP) ? '0 : rr_inc[PW-1:0];

  logic owner_req;
  assign owner_req = |(req & grant_q);

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    gidx_d     = gidx_q;
    rr_ptr_d   = rr_ptr_q;
    rst_cnt_d  = rst_cnt_q;
    sess_cnt_d = sess_cnt_q;
    win_d      = win_q;
    tmo_d      = tmo_q;
    unique case (state_q)
      StIdle: begin
        grant_d = '0;
        if (sel_found) begin
          grant_d   = {{(NUM_PLAYERS-1){1'b0}}, 1'b1} << sel_idx;
          gidx_d    = sel_idx;
          rst_cnt_d = 1'b0;
          state_d   = StGameRst;
        end
      end
      StGameRst: begin
        if (rst_cnt_q) begin
          sess_cnt_d = '0;
          state_d    = StPlay;
        end else begin
          rst_cnt_d = 1'b1;
        end
      end
      StPlay: begin
        if (sess_cnt_q != 16'hFFFF) sess_cnt_d = sess_cnt_q + 16'd1;
        win_d = 1'b0;
        tmo_d = 1'b0;
        // Exit causes in priority order: victory, doom, abort, timeout.
        if (game_stage == 3'd5) begin
          win_d   = 1'b1;
          state_d = StDone;
        end else if (game_stage == 3'd6 || !owner_req) begin
          state_d = StDone;
        end else if (sess_cnt_q == TimeoutLast) begin
          tmo_d   = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        grant_d  = '0;
        rr_ptr_d = rr_next;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      gidx_q     <= '0;
      rr_ptr_q   <= '0;
      rst_cnt_q  <= 1'b0;
      sess_cnt_q <= '0;
      win_q      <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      gidx_q     <= gidx_d;
      rr_ptr_q   <= rr_ptr_d;
      rst_cnt_q  <= rst_cnt_d;
      sess_cnt_q <= sess_cnt_d;
      win_q      <= win_d;
      tmo_q      <= tmo_d;
    end
  end

  logic in_play, in_done;
  assign in_play        = (state_q == StPlay);
  assign in_done        = (state_q == StDone);
  assign busy           = (state_q != StIdle);
  assign game_rst_n     = in_play;
  assign grant          = grant_q;
  assign result_valid   = in_done;
  assign result_win     = in_done & win_q;
  assign result_timeout = in_done & tmo_q;
  assign result_player  = in_done ? gidx_q : '0;

  // AND-OR mux on the one-hot grant: everything is zero while nobody owns the game.
  always_comb begin
    game_animal_in          = '0;
    game_animal_button      = 1'b0;
    game_guess_in           = '0;
    game_guess_button       = 1'b0;
    game_quiz_answer_1      = '0;
    game_quiz_answer_2      = '0;
    game_quiz_answer_3      = '0;
    game_quiz_submit_button = 1'b0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (grant_q[i]) begin
        game_animal_in          = game_animal_in | ply_animal_in[2*i +: 2];
        game_animal_button      = game_animal_button | ply_animal_button[i];
        game_guess_in           = game_guess_in | ply_guess_in[32*i +: 32];
        game_guess_button       = game_guess_button | ply_guess_button[i];
        game_quiz_answer_1      = game_quiz_answer_1 | ply_quiz_answers[15*i +: 5];
        game_quiz_answer_2      = game_quiz_answer_2 | ply_quiz_answers[15*i+5 +: 5];
        game_quiz_answer_3      = game_quiz_answer_3 | ply_quiz_answers[15*i+10 +: 5];
        game_quiz_submit_button = game_quiz_submit_button | ply_quiz_submit[i];
      end
    end
    game_animal_button      = game_animal_button & in_play;
    game_guess_button       = game_guess_button & in_play;
    game_quiz_submit_button = game_quiz_submit_button & in_play;
  end

`ifdef LOTTO_ARB_SCOREBOARD_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      win_count <= '0;
    end else if (in_done && win_q) begin
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        if (grant_q[i] && win_count[8*i +: 8] != 8'hFF) begin
          win_count[8*i +: 8] <= win_count[8*i +: 8] + 8'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_lotto_session_arbiter.sv
// Directed bench for lotto_session_arbiter (4 players, 8-cycle timeout).
module tb_lotto_session_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req;
  logic [7:0]   ply_animal_in;
  logic [3:0]   ply_animal_button;
  logic [127:0] ply_guess_in;
  logic [3:0]   ply_guess_button;
  logic [59:0]  ply_quiz_answers;
  logic [3:0]   ply_quiz_submit;
  logic [2:0]   game_stage;
  logic         game_rst_n;
  logic [1:0]   game_animal_in;
  logic         game_animal_button;
  logic [31:0]  game_guess_in;
  logic         game_guess_button;
  logic [4:0]   game_quiz_answer_1, game_quiz_answer_2, game_quiz_answer_3;
  logic         game_quiz_submit_button;
  logic [3:0]   grant;
  logic         busy, result_valid, result_win, result_timeout;
  logic [1:0]   result_player;
`ifdef LOTTO_ARB_SCOREBOARD_EN
  logic [31:0]  win_count;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lotto_session_arbiter #(
    .NUM_PLAYERS   (4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .req                    (req),
    .ply_animal_in          (ply_animal_in),
    .ply_animal_button      (ply_animal_button),
    .ply_guess_in           (ply_guess_in),
    .ply_guess_button       (ply_guess_button),
    .ply_quiz_answers       (ply_quiz_answers),
    .ply_quiz_submit        (ply_quiz_submit),
    .game_stage             (game_stage),
    .game_rst_n             (game_rst_n),
    .game_animal_in         (game_animal_in),
    .game_animal_button     (game_animal_button),
    .game_guess_in          (game_guess_in),
    .game_guess_button      (game_guess_button),
    .game_quiz_answer_1     (game_quiz_answer_1),
    .game_quiz_answer_2     (game_quiz_answer_2),
    .game_quiz_answer_3     (game_quiz_answer_3),
    .game_quiz_submit_button(game_quiz_submit_button),
    .grant                  (grant),
    .busy                   (busy),
    .result_valid           (result_valid),
    .result_win             (result_win),
    .result_timeout         (result_timeout),
    .result_player          (result_player)
`ifdef LOTTO_ARB_SCOREBOARD_EN
    ,
    .win_count              (win_count)
`endif
  );

  typedef struct {
    logic [3:0] req;
    logic [2:0] stage;
    logic [3:0] gbtn;
    logic [3:0] egrant;
    logic       ebusy;
    logic       ernn;
    logic       erv;
    logic       erw;
    logic       ert;
    logic [1:0] erp;
    logic       egbo;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_guess(input logic [3:0] g);
    logic [31:0] r = '0;
    for (int i = 0; i < 4; i++) if (g[i]) r = 32'hC0DE_0000 + 32'(i);
    return r;
  endfunction

  function automatic logic [4:0] exp_ans1(input logic [3:0] g);
    logic [4:0] r = '0;
    for (int i = 0; i < 4; i++) if (g[i]) r = 5'(i + 1);
    return r;
  endfunction

  task automatic wait_done(input int max_cyc, output int play, output logic got,
                           output logic w, output logic t, output logic [1:0] p);
    play = 0; got = 1'b0; w = 1'b0; t = 1'b0; p = '0;
    for (int k = 0; k < max_cyc && !got; k++) begin
      @(negedge clk); #1;
      if (game_rst_n) play++;
      if (result_valid) begin
        got = 1'b1; w = result_win; t = result_timeout; p = result_player;
      end
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " grant"}, 32'(grant), 0);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " game_rst_n"}, 32'(game_rst_n), 0);
    chk({tag, " result_valid"}, 32'(result_valid), 0);
    chk({tag, " result_win"}, 32'(result_win), 0);
    chk({tag, " result_timeout"}, 32'(result_timeout), 0);
    chk({tag, " guess_button"}, 32'(game_guess_button), 0);
    chk({tag, " guess_in"}, game_guess_in, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         play, cnt;
    logic       got, w, t;
    logic [1:0] p;

    rst = 1'b1; req = '0; game_stage = '0;
    ply_animal_in = 8'b11_10_01_00; ply_animal_button = '0; ply_guess_button = '0;
    ply_quiz_submit = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      ply_guess_in[32*i +: 32]     = 32'hC0DE_0000 + 32'(i);
      ply_quiz_answers[15*i +: 15] = {5'(i + 9), 5'(i + 5), 5'(i + 1)};
    end

    //            req      st  gbtn     grant   bsy rn rv rw rt rp gbo
    tbl.push_back('{4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{4'b0001, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{4'b0001, 0, 4'b0001, 4'b0001, 1, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{4'b0001, 0, 4'b0000, 4'b0001, 1, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{4'b0001, 0, 4'b0001, 4'b0001, 1, 1, 0, 0, 0, 0, 1});
    tbl.push_back('{4'b0001, 0, 4'b0010, 4'b0001, 1, 1, 0, 0, 0, 0, 0});
    tbl.push_back('{4'b0001, 5, 4'b0000, 4'b0001, 1, 1, 0, 0, 0, 0, 0});
    tbl.push_back('{4'b0000, 0, 4'b0001, 4'b0001, 1, 0, 1, 1, 0, 0, 0});
    tbl.push_back('{4'b1011, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{4'b1011, 0, 4'b0010, 4'b0010, 1, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{4'b0111, 0, 4'b0000, 4'b0010, 1, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{4'b1011, 6, 4'b0010, 4'b0010, 1, 1, 0, 0, 0, 0, 1});
    tbl.push_back('{4'b1011, 0, 4'b0000, 4'b0010, 1, 0, 1, 0, 0, 1, 0});
    tbl.push_back('{4'b1011, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{4'b1011, 0, 4'b0000, 4'b1000, 1, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{4'b0011, 0, 4'b0000, 4'b1000, 1, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{4'b0011, 0, 4'b1000, 4'b1000, 1, 1, 0, 0, 0, 0, 1});
    tbl.push_back('{4'b0011, 0, 4'b0000, 4'b1000, 1, 0, 1, 0, 0, 3, 0});
    tbl.push_back('{4'b0011, 7, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{4'b0011, 7, 4'b0000, 4'b0001, 1, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{4'b0011, 7, 4'b0000, 4'b0001, 1, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{4'b0011, 3, 4'b0000, 4'b0001, 1, 1, 0, 0, 0, 0, 0});
    tbl.push_back('{4'b0011, 4, 4'b0000, 4'b0001, 1, 1, 0, 0, 0, 0, 0});
    tbl.push_back('{4'b0011, 7, 4'b0000, 4'b0001, 1, 1, 0, 0, 0, 0, 0});
    tbl.push_back('{4'b0011, 5, 4'b0000, 4'b0001, 1, 1, 0, 0, 0, 0, 0});
    tbl.push_back('{4'b0000, 0, 4'b0000, 4'b0001, 1, 0, 1, 1, 0, 0, 0});
    tbl.push_back('{4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0, 0});

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < tbl.size(); k++) begin
      if (k != 0) @(negedge clk);
      req = tbl[k].req; game_stage = tbl[k].stage; ply_guess_button = tbl[k].gbtn;
      #1;
      chk($sformatf("row%0d grant", k), 32'(grant), 32'(tbl[k].egrant));
      chk($sformatf("row%0d busy", k), 32'(busy), 32'(tbl[k].ebusy));
      chk($sformatf("row%0d game_rst_n", k), 32'(game_rst_n), 32'(tbl[k].ernn));
      chk($sformatf("row%0d result_valid", k), 32'(result_valid), 32'(tbl[k].erv));
      chk($sformatf("row%0d result_win", k), 32'(result_win), 32'(tbl[k].erw));
      chk($sformatf("row%0d result_timeout", k), 32'(result_timeout), 32'(tbl[k].ert));
      chk($sformatf("row%0d result_player", k), 32'(result_player), 32'(tbl[k].erp));
      chk($sformatf("row%0d guess_button", k), 32'(game_guess_button), 32'(tbl[k].egbo));
      chk($sformatf("row%0d submit_button", k), 32'(game_quiz_submit_button),
          32'(tbl[k].ernn));
      chk($sformatf("row%0d guess_in", k), game_guess_in, exp_guess(tbl[k].egrant));
      chk($sformatf("row%0d answer_1", k), 32'(game_quiz_answer_1),
          32'(exp_ans1(tbl[k].egrant)));
    end

    // Timeout session: player 2 alone, stage held at 0.
    @(negedge clk);
    req = 4'b0100; game_stage = 3'd0; ply_guess_button = '0;
    #1;
    chk("tmo idle grant", 32'(grant), 0);
    wait_done(30, play, got, w, t, p);
    req = '0;
    chk("tmo done seen", 32'(got), 1);
    chk("tmo play cycles", 32'(play), 8);
    chk("tmo result_timeout", 32'(t), 1);
    chk("tmo result_win", 32'(w), 0);
    chk("tmo result_player", 32'(p), 2);

    // Reset in the middle of PLAY: no report, and rr_ptr returns to 0.
    @(negedge clk);
    req = 4'b0001;
    repeat (3) @(negedge clk);
    #1;
    chk("rst-test in play", 32'(game_rst_n), 1);
    chk("rst-test grant", 32'(grant), 32'(4'b0001));
    @(negedge clk);
    rst = 1'b1; ply_guess_button = 4'b0001;
    @(negedge clk);
    rst = 1'b0; req = '0;
    #1;
    chk_reset_outputs("after rst");
    cnt = 0;
    repeat (4) begin
      @(negedge clk); #1;
      if (result_valid) cnt++;
    end
    chk("no result after abort", 32'(cnt), 0);
    ply_guess_button = '0;
    @(negedge clk);
    req = 4'b1010;
    @(negedge clk);
    #1;
    chk("rr_ptr reset grant", 32'(grant), 32'(4'b0010));
    req = '0;
    wait_done(10, play, got, w, t, p);
    chk("abort done seen", 32'(got), 1);
    chk("abort result_win", 32'(w), 0);
    chk("abort result_timeout", 32'(t), 0);
    chk("abort result_player", 32'(p), 1);

`ifdef LOTTO_ARB_SCOREBOARD_EN
    // Player 2 wins 256 sessions; counter saturates.
    @(negedge clk);
    req = 4'b0100; game_stage = 3'd5;
    cnt = 0;
    for (int k = 0; k < 256 * 6 + 20 && cnt < 256; k++) begin
      @(negedge clk); #1;
      if (result_valid && result_win && result_player == 2'd2) cnt++;
    end
    req = '0; game_stage = '0;
    chk("score wins observed", 32'(cnt), 256);
    @(negedge clk); #1;
    chk("score p2 saturated", 32'(win_count[23:16]), 255);
    chk("score p0", 32'(win_count[7:0]), 0);
    chk("score p1", 32'(win_count[15:8]), 0);
    req = 4'b0100;
    repeat (3) @(negedge clk);
    #1;
    chk("score in play", 32'(game_rst_n), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; req = '0;
    #1;
    chk("score cleared", win_count, 0);
    chk_reset_outputs("score rst");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
